// File: rtl/flash_boot_loader.sv
// rtl/flash_boot_loader.sv - loads a flash boot image (header + payload) into RAM and releases the CPU
module flash_boot_loader #(
    parameter logic [23:0] IMAGE_ADDRESS  = 24'h100000,
    parameter logic [15:0] MAGIC          = 16'hB007,
    parameter int          MAX_WORDS      = 4096,
    parameter int          TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        reboot,
    output logic        rd_start,
    output logic [23:0] rd_address,
    output logic [23:0] rd_word_count,
    input  logic        rd_strobe,
    input  logic [31:0] rd_data,
    input  logic        rd_done,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_n_reset,
    output logic        boot_done,
    output logic [1:0]  boot_error
);

    typedef enum logic [3:0] {
        IDLE,
        HDR_REQ,
        HDR_WAIT,
        HDR_REL,
        CHECK,
        PAY_REQ,
        PAY_WAIT,
        PAY_REL,
        RUN,
        ERROR
    } state_t;

    localparam logic [23:0] PAY_ADDRESS  = IMAGE_ADDRESS + 24'd4;
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] MAX_WORDS_W  = 32'(MAX_WORDS);

    state_t      state;
    state_t      state_next;
    logic [31:0] header;
    logic [15:0] word_idx;
    logic [31:0] timer;
    logic [1:0]  err_code;
    logic        err_load;
    logic [1:0]  err_val;

    logic [15:0] n_words;
    logic        timer_expired;
    logic        n_bad;

    assign n_words       = header[15:0];
    assign timer_expired = (timer == TIMEOUT_LAST);
    assign n_bad         = (n_words == 16'd0) || ({16'd0, n_words} > MAX_WORDS_W);

    // State register
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and state-decoded outputs; rd_start is purely a function
    // of state so it drops the same cycle ERROR/REL is entered or reset hits
    always_comb begin
        state_next    = state;
        err_load      = 1'b0;
        err_val       = 2'd0;
        rd_start      = 1'b0;
        rd_address    = 24'd0;
        rd_word_count = 24'd0;
        cpu_n_reset   = 1'b0;
        boot_done     = 1'b0;
        boot_error    = 2'd0;
        case (state)
            IDLE: begin
                state_next = HDR_REQ;
            end
            HDR_REQ: begin
                rd_start      = 1'b1;
                rd_address    = IMAGE_ADDRESS;
                rd_word_count = 24'd1;
                state_next    = HDR_WAIT;
            end
            HDR_WAIT: begin
                rd_start      = 1'b1;
                rd_address    = IMAGE_ADDRESS;
                rd_word_count = 24'd1;
                if (rd_done) begin
                    state_next = HDR_REL;
                end else if (timer_expired) begin
                    state_next = ERROR;
                    err_load   = 1'b1;
                    err_val    = 2'd3;
                end
            end
            HDR_REL: begin
                if (!rd_done) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (header[31:16] != MAGIC) begin
                    state_next = ERROR;
                    err_load   = 1'b1;
                    err_val    = 2'd1;
                end else if (n_bad) begin
                    state_next = ERROR;
                    err_load   = 1'b1;
                    err_val    = 2'd2;
                end else begin
                    state_next = PAY_REQ;
                end
            end
            PAY_REQ: begin
                rd_start      = 1'b1;
                rd_address    = PAY_ADDRESS;
                rd_word_count = {8'd0, n_words};
                state_next    = PAY_WAIT;
            end
            PAY_WAIT: begin
                rd_start      = 1'b1;
                rd_address    = PAY_ADDRESS;
                rd_word_count = {8'd0, n_words};
                if (rd_done) begin
                    state_next = PAY_REL;
                end else if (timer_expired) begin
                    state_next = ERROR;
                    err_load   = 1'b1;
                    err_val    = 2'd3;
                end
            end
            PAY_REL: begin
                if (!rd_done) begin
                    if (word_idx == n_words) begin
                        state_next = RUN;
                    end else begin
                        state_next = ERROR;
                        err_load   = 1'b1;
                        err_val    = 2'd3;
                    end
                end
            end
            RUN: begin
                cpu_n_reset = 1'b1;
                boot_done   = 1'b1;
                if (reboot) begin
                    state_next = IDLE;
                end
            end
            ERROR: begin
                boot_error = err_code;
                if (reboot) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: header capture, payload write port, word index, timeout timer, error code
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            header    <= 32'd0;
            word_idx  <= 16'd0;
            timer     <= 32'd0;
            err_code  <= 2'd0;
            mem_we    <= 1'b0;
            mem_addr  <= 16'd0;
            mem_wdata <= 32'd0;
        end else begin
            mem_we <= 1'b0;

            if (state == HDR_REQ || state == PAY_REQ) begin
                timer <= 32'd0;
            end else if (state == HDR_WAIT || state == PAY_WAIT) begin
                timer <= timer + 32'd1;
            end

            if (state == HDR_WAIT && rd_strobe) begin
                header <= rd_data;
            end

            if (state == IDLE || state_next == IDLE) begin
                word_idx <= 16'd0;
            end else if (state == PAY_WAIT && rd_strobe) begin
                mem_we    <= 1'b1;
                mem_wdata <= rd_data;
                mem_addr  <= word_idx;
                word_idx  <= word_idx + 16'd1;
            end

            if (err_load) begin
                err_code <= err_val;
            end else if (state_next == IDLE) begin
                err_code <= 2'd0;
            end
        end
    end

endmodule

// File: tb/tb_flash_boot_loader.sv
// tb/tb_flash_boot_loader.sv - randomized self-checking bench for flash_boot_loader
module tb_flash_boot_loader;

    localparam logic [23:0] IMAGE_ADDRESS = 24'h100000;
    localparam logic [15:0] MAGIC         = 16'hB007;
    localparam int          MAX_WORDS     = 4096;
    localparam int          TIMEOUT       = 100;
    localparam logic [23:0] PAY_ADDR      = IMAGE_ADDRESS + 24'd4;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        reboot = 1'b0;
    logic        rd_start;
    logic [23:0] rd_address;
    logic [23:0] rd_word_count;
    logic        rd_strobe = 1'b0;
    logic [31:0] rd_data = 32'd0;
    logic        rd_done = 1'b0;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_n_reset;
    logic        boot_done;
    logic [1:0]  boot_error;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    logic [31:0] xfer_q[$];
    logic [31:0] pay_q[$];
    int          exp_cyc_q[$];
    logic [15:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          wr_cyc_q[$];

    flash_boot_loader #(
        .IMAGE_ADDRESS (IMAGE_ADDRESS),
        .MAGIC         (MAGIC),
        .MAX_WORDS     (MAX_WORDS),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .reboot       (reboot),
        .rd_start     (rd_start),
        .rd_address   (rd_address),
        .rd_word_count(rd_word_count),
        .rd_strobe    (rd_strobe),
        .rd_data      (rd_data),
        .rd_done      (rd_done),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_n_reset  (cpu_n_reset),
        .boot_done    (boot_done),
        .boot_error   (boot_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM write monitor
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
            wr_cyc_q.push_back(cyc);
        end
    end

    task automatic wait_start(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rd_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL %s rd_start_request: got %b required 1 within 20 cycles", name, rd_start);
        end
    endtask

    // Flash reader responder: called at the negedge where the request is visible
    task automatic do_transfer(input bit done_last, input string name);
        int gap;
        int last;
        last = xfer_q.size() - 1;
        @(negedge clk);
        reboot = 1'b1;
        for (int i = 0; i <= last; i++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                rd_strobe = 1'b0;
                rd_done   = 1'b0;
                @(negedge clk);
                reboot = 1'b0;
            end
            rd_strobe = 1'b1;
            rd_data   = xfer_q[i];
            rd_done   = done_last && (i == last);
            exp_cyc_q.push_back(cyc + 1);
            @(negedge clk);
            reboot = 1'b0;
        end
        rd_strobe = 1'b0;
        if (!done_last) begin
            rd_done = 1'b1;
            @(negedge clk);
        end
        tests_run++;
        if (rd_start !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s rd_start_release: got %b required 0", name, rd_start);
        end
        rd_done   = 1'b0;
        rd_strobe = 1'b1;
        rd_data   = $urandom;
        @(negedge clk);
        rd_strobe = 1'b0;
    endtask

    // Full boot from IDLE against the spec-level outcome model
    task automatic run_boot(input logic [31:0] hdr, input bit done_last, input string name);
        int e;
        int n;
        int nstr;
        int exp_wr;
        int n0;
        nstr = pay_q.size();
        n    = int'(hdr[15:0]);
        if (hdr[31:16] != MAGIC)            e = 1;
        else if (n == 0 || n > MAX_WORDS)   e = 2;
        else if (nstr != n)                 e = 3;
        else                                e = 0;
        exp_wr = (e == 0 || e == 3) ? nstr : 0;

        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        exp_cyc_q.delete();

        wait_start(name);
        tests_run++;
        if (rd_address !== IMAGE_ADDRESS || rd_word_count !== 24'd1) begin
            tests_failed++;
            $display("FAIL %s hdr_request: got addr %h count %0d required addr %h count 1",
                     name, rd_address, rd_word_count, IMAGE_ADDRESS);
        end
        xfer_q.delete();
        xfer_q.push_back(hdr);
        do_transfer(done_last, name);
        exp_cyc_q.delete();

        if (e == 0 || e == 3) begin
            wait_start(name);
            tests_run++;
            if (rd_address !== PAY_ADDR || rd_word_count !== {8'd0, hdr[15:0]}) begin
                tests_failed++;
                $display("FAIL %s pay_request: got addr %h count %0d required addr %h count %0d",
                         name, rd_address, rd_word_count, PAY_ADDR, n);
            end
            xfer_q = pay_q;
            do_transfer(done_last, name);
        end

        for (int i = 0; i < 10; i++) begin
            if (boot_done === 1'b1 || boot_error !== 2'd0) break;
            @(negedge clk);
        end

        tests_run++;
        if (boot_error !== 2'(e) || boot_done !== (e == 0) || cpu_n_reset !== (e == 0) || rd_start !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s status: got err %0d done %b cpu_n_reset %b rd_start %b required err %0d done %b cpu_n_reset %b rd_start 0",
                     name, boot_error, boot_done, cpu_n_reset, rd_start, e, e == 0, e == 0);
        end

        tests_run++;
        if (wr_addr_q.size() != exp_wr) begin
            tests_failed++;
            $display("FAIL %s write_count: got %0d required %0d", name, wr_addr_q.size(), exp_wr);
        end else begin
            for (int i = 0; i < exp_wr; i++) begin
                tests_run++;
                if (wr_addr_q[i] !== 16'(i) || wr_data_q[i] !== pay_q[i] || wr_cyc_q[i] != exp_cyc_q[i]) begin
                    tests_failed++;
                    $display("FAIL %s write[%0d]: got addr %0d data %h cycle %0d required addr %0d data %h cycle %0d",
                             name, i, wr_addr_q[i], wr_data_q[i], wr_cyc_q[i], i, pay_q[i], exp_cyc_q[i]);
                end
            end
        end

        if (e == 0) begin
            n0 = wr_addr_q.size();
            rd_strobe = 1'b1;
            rd_data   = $urandom;
            repeat (2) @(negedge clk);
            rd_strobe = 1'b0;
            @(negedge clk);
            tests_run++;
            if (wr_addr_q.size() != n0 || boot_done !== 1'b1) begin
                tests_failed++;
                $display("FAIL %s strobe_in_run: got writes %0d done %b required writes %0d done 1",
                         name, wr_addr_q.size(), boot_done, n0);
            end
        end
    endtask

    task automatic reboot_pulse(input string name);
        reboot = 1'b1;
        @(negedge clk);
        reboot = 1'b0;
        tests_run++;
        if (cpu_n_reset !== 1'b0 || boot_done !== 1'b0 || boot_error !== 2'd0 || rd_start !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s reboot_status: got cpu_n_reset %b done %b err %0d rd_start %b required 0 0 0 0",
                     name, cpu_n_reset, boot_done, boot_error, rd_start);
        end
    endtask

    task automatic fill_random(input int n);
        pay_q.delete();
        for (int i = 0; i < n; i++) pay_q.push_back($urandom);
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (rd_start !== 1'b0 || rd_address !== 24'd0 || rd_word_count !== 24'd0 || mem_we !== 1'b0 ||
            mem_addr !== 16'd0 || mem_wdata !== 32'd0 || cpu_n_reset !== 1'b0 || boot_done !== 1'b0 ||
            boot_error !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_values: got start %b addr %h cnt %0d we %b maddr %0d wdata %h cpu %b done %b err %0d required all 0",
                     rd_start, rd_address, rd_word_count, mem_we, mem_addr, mem_wdata, cpu_n_reset, boot_done, boot_error);
        end
        n_reset = 1'b1;
    endtask

    task automatic test_valid_boot();
        pay_q = '{32'd11, 32'd22, 32'd33};
        run_boot(32'hB0070003, 1'b0, "valid_boot");
    endtask

    task automatic test_reboot();
        reboot_pulse("reboot_run");
        fill_random(5);
        run_boot(32'hB0070005, 1'b0, "reboot_reload");
    endtask

    task automatic test_bad_header();
        reboot_pulse("bad_magic");
        fill_random(3);
        run_boot(32'h12340003, 1'b0, "bad_magic");
        reboot_pulse("bad_len0");
        run_boot(32'hB0070000, 1'b0, "bad_len0");
        reboot_pulse("bad_len_big");
        run_boot(32'hB0071001, 1'b0, "bad_len_big");
    endtask

    task automatic test_count_mismatch();
        reboot_pulse("short_payload");
        fill_random(3);
        run_boot(32'hB0070004, 1'b0, "short_payload");
        reboot_pulse("long_payload");
        run_boot(32'hB0070002, 1'b1, "long_payload");
    endtask

    task automatic test_back_to_back();
        int n;
        for (int k = 0; k < 6; k++) begin
            reboot_pulse("random_boot");
            n = $urandom_range(1, 8);
            fill_random(n);
            run_boot({MAGIC, 16'(n)}, 1'($urandom_range(0, 1)), "random_boot");
        end
    endtask

    task automatic test_timeout();
        int cnt;
        reboot_pulse("timeout");
        wait_start("timeout");
        cnt = 0;
        @(negedge clk);
        for (int i = 0; i < 200; i++) begin
            if (rd_start !== 1'b1) break;
            cnt++;
            @(negedge clk);
        end
        tests_run++;
        if (cnt != TIMEOUT || boot_error !== 2'd3 || cpu_n_reset !== 1'b0 || boot_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout: got wait_cycles %0d err %0d cpu_n_reset %b done %b required %0d 3 0 0",
                     cnt, boot_error, cpu_n_reset, boot_done, TIMEOUT);
        end
    endtask

    task automatic test_reset_mid_transfer();
        reboot_pulse("reset_mid");
        wait_start("reset_mid");
        xfer_q.delete();
        xfer_q.push_back(32'hB0070005);
        do_transfer(1'b0, "reset_mid");
        wait_start("reset_mid");
        @(negedge clk);
        rd_strobe = 1'b1;
        rd_data   = $urandom;
        @(negedge clk);
        rd_data   = $urandom;
        @(negedge clk);
        rd_strobe = 1'b0;
        #2 n_reset = 1'b0;
        #1;
        tests_run++;
        if (rd_start !== 1'b0 || rd_address !== 24'd0 || rd_word_count !== 24'd0 || mem_we !== 1'b0 ||
            mem_addr !== 16'd0 || mem_wdata !== 32'd0 || cpu_n_reset !== 1'b0 || boot_done !== 1'b0 ||
            boot_error !== 2'd0) begin
            tests_failed++;
            $display("FAIL async_reset: got start %b addr %h cnt %0d we %b maddr %0d wdata %h cpu %b done %b err %0d required all 0",
                     rd_start, rd_address, rd_word_count, mem_we, mem_addr, mem_wdata, cpu_n_reset, boot_done, boot_error);
        end
        @(negedge clk);
        n_reset = 1'b1;
        fill_random(4);
        run_boot(32'hB0070004, 1'b1, "after_reset");
    endtask

    initial begin
        test_reset();
        test_valid_boot();
        test_reboot();
        test_bad_header();
        test_count_mismatch();
        test_back_to_back();
        test_timeout();
        test_reset_mid_transfer();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/flash_boot_loader.md
FLASH_BOOT_LOADER -- requirements
Module: flash_boot_loader

Interface
REQ-001 The block SHALL have parameter IMAGE_ADDRESS, default 24'h100000, the flash byte address of the image header.
REQ-002 The block SHALL have parameter MAGIC, default 16'hB007, the required header magic.
REQ-003 The block SHALL have parameter MAX_WORDS, default 4096, the largest accepted payload length in words.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 1000000, the per-transfer limit in clk cycles.
REQ-005 The block SHALL have port clk, input, 1, the single system clock.
REQ-006 The block SHALL have port n_reset, input, 1, an asynchronous active-low reset.
REQ-007 The block SHALL have port reboot, input, 1, a one-cycle request to reload the image.
REQ-008 The block SHALL have ports rd_start (output, 1), rd_address (output, 24) and rd_word_count (output, 24), the flash reader request.
REQ-009 The block SHALL have ports rd_strobe (input, 1), rd_data (input, 32) and rd_done (input, 1), the flash reader response.
REQ-010 The block SHALL have ports mem_we (output, 1), mem_addr (output, 16, word address) and mem_wdata (output, 32), the RAM write port.
REQ-011 The block SHALL have ports cpu_n_reset (output, 1), boot_done (output, 1) and boot_error (output, 2), the boot status.

Function
REQ-012 The block SHALL implement these states: IDLE, HDR_REQ, HDR_WAIT, HDR_REL, CHECK, PAY_REQ, PAY_WAIT, PAY_REL, RUN, ERROR.
REQ-013 IDLE SHALL last 1 cycle and then go to HDR_REQ.
REQ-014 HDR_REQ SHALL drive rd_address=IMAGE_ADDRESS and rd_word_count=1, assert rd_start, and go to HDR_WAIT.
REQ-015 In HDR_WAIT, each cycle with rd_strobe=1 SHALL capture rd_data into the header register.
REQ-016 In HDR_WAIT, rd_done=1 SHALL cause a move to HDR_REL.
REQ-017 HDR_REL SHALL deassert rd_start and wait for rd_done=0, then go to CHECK.
REQ-018 rd_start SHALL remain asserted from the REQ state until rd_done is sampled high, and never longer.
REQ-019 CHECK (1 cycle) SHALL go to ERROR with code 1 when header[31:16]!=MAGIC.
REQ-020 Otherwise, CHECK SHALL go to ERROR with code 2 when N=header[15:0] is 0 or N>MAX_WORDS.
REQ-021 Otherwise, CHECK SHALL go to PAY_REQ.
REQ-022 PAY_REQ SHALL drive rd_address=IMAGE_ADDRESS+4 (24-bit wrap) and rd_word_count=N zero-extended, and SHALL never issue rd_word_count=0.
REQ-023 In PAY_WAIT, each cycle with rd_strobe=1 SHALL produce, one cycle later, mem_we=1 for exactly 1 cycle, with mem_wdata=rd_data and mem_addr equal to the word index (0,1,2,...).
REQ-024 The word index SHALL increment after each write and is 16 bits wide.
REQ-025 In PAY_WAIT, rd_done=1 SHALL cause a move to PAY_REL.
REQ-026 PAY_REL SHALL wait for rd_done=0, then go to RUN if the strobe count equals N, else go to ERROR with code 3.
REQ-027 If rd_strobe and rd_done are high in the same cycle, the word SHALL be counted and written before the count comparison.
REQ-028 A cycle counter SHALL be cleared on entry to HDR_WAIT and PAY_WAIT.
REQ-029 The WAIT state SHALL go to ERROR with code 3 if the counter reaches TIMEOUT_CYCLES without rd_done.
REQ-030 On any entry to ERROR, rd_start SHALL be deasserted.
REQ-031 RUN SHALL assert cpu_n_reset=1 and boot_done=1.
REQ-032 ERROR SHALL hold cpu_n_reset=0 and boot_done=0 and keep boot_error at its code.
REQ-033 boot_error SHALL be 0 in every state other than ERROR.
REQ-034 reboot=1 in RUN or ERROR SHALL cause a move to IDLE next cycle, with cpu_n_reset=0 and boot_done=0, boot_error cleared, and the word index cleared.
REQ-035 reboot SHALL be ignored in all other states.
REQ-036 rd_strobe in any state other than HDR_WAIT or PAY_WAIT SHALL be ignored and SHALL produce no mem_we.
REQ-037 cpu_n_reset SHALL be 0 in every state except RUN.

Reset
REQ-038 Asserting n_reset SHALL asynchronously force: state IDLE, rd_start=0, rd_address=0, rd_word_count=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_n_reset=0, boot_done=0, boot_error=0, all counters 0.
REQ-039 Reset asserted mid-transfer SHALL drop rd_start immediately.
REQ-040 After reset deasserts, the sequence SHALL restart from IDLE.

Verification
REQ-041 Valid boot: header 32'hB0070003, payload 11,22,33 -> writes addr 0..2 with 11,22,33, one cycle after each strobe, then RUN, cpu_n_reset=1, boot_done=1.
REQ-042 Bad magic: header 32'h12340003 -> ERROR, boot_error=1, no mem_we, cpu_n_reset=0.
REQ-043 Bad length: header 32'hB0070000 -> boot_error=2; header 32'hB0071001 with MAX_WORDS=4096 -> boot_error=2.
REQ-044 Timeout: rd_done never asserted with TIMEOUT_CYCLES=100 -> ERROR, boot_error=3, rd_start=0 exactly 100 cycles after HDR_WAIT entry.
REQ-045 Short payload: N=4 but only 3 strobes before rd_done -> boot_error=3.
REQ-046 Reboot and reset: reboot pulse in RUN -> cpu_n_reset=0 next cycle and a full reload; n_reset pulse during PAY_WAIT -> all outputs at reset values asynchronously, then a clean reload.
